// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Tuse/Tnew stall and forwarding control for the 5-stage MIPS
//               pipeline, with shadow E/M/W records and a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_wa,
  input  logic              id_regwrite,
  input  logic              id_tuse_rs0,
  input  logic              id_tuse_rs1,
  input  logic              id_tuse_rt0,
  input  logic              id_tuse_rt1,
  input  logic              id_tuse_rt2,
  input  logic [1:0]        id_tnew,
  output logic              stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd_id_rs,
  output logic [1:0]        fwd_id_rt,
  output logic [1:0]        fwd_ex_rs,
  output logic [1:0]        fwd_ex_rt,
  output logic              fwd_mem_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [REG_AW-1:0] c_zero_reg = '0;

  // Only the fields each later consumer reads are kept per stage.
  logic [REG_AW-1:0] r_e_wa, r_e_rs, r_e_rt;
  logic              r_e_rw;
  logic [1:0]        r_e_tnew;
  logic [REG_AW-1:0] r_m_wa, r_m_rt;
  logic              r_m_rw;
  logic [1:0]        r_m_tnew;
  logic [REG_AW-1:0] r_w_wa;
  logic              r_w_rw;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_e_live, w_m_live, w_w_live;
  logic w_stall;
  logic w_unused_rt2;

  // A Tuse=2 consumer is always covered by forwarding since Tnew never exceeds 2.
  assign w_unused_rt2 = id_tuse_rt2;

  assign w_e_live = r_e_rw && (r_e_wa != c_zero_reg);
  assign w_m_live = r_m_rw && (r_m_wa != c_zero_reg);
  assign w_w_live = r_w_rw && (r_w_wa != c_zero_reg);

  function automatic logic need_stall(
    input logic              live,
    input logic [REG_AW-1:0] wa,
    input logic [1:0]        tnew,
    input logic [REG_AW-1:0] src,
    input logic              tuse0,
    input logic              tuse1
  );
    return live && (wa == src) &&
           ((tuse0 && (tnew > 2'd0)) || (tuse1 && (tnew > 2'd1)));
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              m_live,
    input logic [REG_AW-1:0] m_wa,
    input logic [1:0]        m_tnew,
    input logic              w_live,
    input logic [REG_AW-1:0] w_wa
  );
    if (m_live && (m_wa == src) && (m_tnew == 2'd0)) return 2'b01;
    else if (w_live && (w_wa == src))                 return 2'b10;
    else                                              return 2'b00;
  endfunction

  always_comb begin
    w_stall = need_stall(w_e_live, r_e_wa, r_e_tnew, id_rs, id_tuse_rs0, id_tuse_rs1)
            | need_stall(w_e_live, r_e_wa, r_e_tnew, id_rt, id_tuse_rt0, id_tuse_rt1)
            | need_stall(w_m_live, r_m_wa, r_m_tnew, id_rs, id_tuse_rs0, id_tuse_rs1)
            | need_stall(w_m_live, r_m_wa, r_m_tnew, id_rt, id_tuse_rt0, id_tuse_rt1);
  end

  assign stall      = w_stall;
  assign ex_bubble  = w_stall & ~hold;
  assign fwd_id_rs  = fwd_sel(id_rs,  w_m_live, r_m_wa, r_m_tnew, w_w_live, r_w_wa);
  assign fwd_id_rt  = fwd_sel(id_rt,  w_m_live, r_m_wa, r_m_tnew, w_w_live, r_w_wa);
  assign fwd_ex_rs  = fwd_sel(r_e_rs, w_m_live, r_m_wa, r_m_tnew, w_w_live, r_w_wa);
  assign fwd_ex_rt  = fwd_sel(r_e_rt, w_m_live, r_m_wa, r_m_tnew, w_w_live, r_w_wa);
  assign fwd_mem_rt = w_w_live && (r_w_wa == r_m_rt);
  assign stall_cnt  = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_wa      <= '0;
      r_e_rs      <= '0;
      r_e_rt      <= '0;
      r_e_rw      <= 1'b0;
      r_e_tnew    <= 2'd0;
      r_m_wa      <= '0;
      r_m_rt      <= '0;
      r_m_rw      <= 1'b0;
      r_m_tnew    <= 2'd0;
      r_w_wa      <= '0;
      r_w_rw      <= 1'b0;
      r_stall_cnt <= '0;
    end else if (!hold) begin
      if (w_stall) begin
        r_e_wa   <= '0;
        r_e_rs   <= '0;
        r_e_rt   <= '0;
        r_e_rw   <= 1'b0;
        r_e_tnew <= 2'd0;
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_e_wa   <= id_wa;
        r_e_rs   <= id_rs;
        r_e_rt   <= id_rt;
        r_e_rw   <= id_regwrite;
        r_e_tnew <= id_tnew;
      end
      r_m_wa   <= r_e_wa;
      r_m_rt   <= r_e_rt;
      r_m_rw   <= r_e_rw;
      r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
      r_w_wa   <= r_m_wa;
      r_w_rw   <= r_m_rw;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Random and directed bench for hazard_unit against a
//               stage-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [4:0]  id_rs, id_rt, id_wa;
  logic        id_regwrite, id_tuse_rs0, id_tuse_rs1;
  logic        id_tuse_rt0, id_tuse_rt1, id_tuse_rt2;
  logic [1:0]  id_tnew;
  logic        stall, ex_bubble, fwd_mem_rt;
  logic [1:0]  fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;
  logic [31:0] stall_cnt;

  hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa), .id_regwrite(id_regwrite),
    .id_tuse_rs0(id_tuse_rs0), .id_tuse_rs1(id_tuse_rs1),
    .id_tuse_rt0(id_tuse_rt0), .id_tuse_rt1(id_tuse_rt1), .id_tuse_rt2(id_tuse_rt2),
    .id_tnew(id_tnew), .stall(stall), .ex_bubble(ex_bubble),
    .fwd_id_rs(fwd_id_rs), .fwd_id_rt(fwd_id_rt),
    .fwd_ex_rs(fwd_ex_rs), .fwd_ex_rt(fwd_ex_rt),
    .fwd_mem_rt(fwd_mem_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: slot 0=EX, 1=MEM, 2=WB; tnew kept as issued, remaining = issued - slot.
  int          m_wa[3], m_rw[3], m_tn[3], m_rs[3], m_rt[3];
  logic [31:0] m_cnt;
  bit          x_stall, x_bub;

  function automatic int rem(int k);
    return (m_tn[k] > k) ? m_tn[k] - k : 0;
  endfunction

  function automatic bit live(int k);
    return (m_rw[k] != 0) && (m_wa[k] != 0);
  endfunction

  function automatic int fsel(int r);
    if (live(1) && m_wa[1] == r && rem(1) == 0) return 1;
    if (live(2) && m_wa[2] == r) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_wa[k] = 0; m_rw[k] = 0; m_tn[k] = 0; m_rs[k] = 0; m_rt[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_eval();
    x_stall = 0;
    for (int k = 0; k < 2; k++) begin
      if (live(k)) begin
        if (m_wa[k] == int'(id_rs) &&
            ((id_tuse_rs0 && rem(k) > 0) || (id_tuse_rs1 && rem(k) > 1))) x_stall = 1;
        if (m_wa[k] == int'(id_rt) &&
            ((id_tuse_rt0 && rem(k) > 0) || (id_tuse_rt1 && rem(k) > 1))) x_stall = 1;
      end
    end
    x_bub = x_stall && !hold;
  endtask

  task automatic model_step();
    model_eval();
    if (!hold) begin
      if (x_bub) m_cnt = m_cnt + 1;
      for (int k = 2; k > 0; k--) begin
        m_wa[k] = m_wa[k-1]; m_rw[k] = m_rw[k-1]; m_tn[k] = m_tn[k-1];
        m_rs[k] = m_rs[k-1]; m_rt[k] = m_rt[k-1];
      end
      if (x_stall) begin
        m_wa[0] = 0; m_rw[0] = 0; m_tn[0] = 0; m_rs[0] = 0; m_rt[0] = 0;
      end else begin
        m_wa[0] = id_wa; m_rw[0] = id_regwrite; m_tn[0] = id_tnew;
        m_rs[0] = id_rs; m_rt[0] = id_rt;
      end
    end
  endtask

  task automatic cmp(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Mid-low-phase check of every output against the model.
  task automatic half();
    @(negedge clk);
    model_eval();
    cmp("stall", stall, x_stall);
    cmp("ex_bubble", ex_bubble, x_bub);
    if (!x_stall) begin
      cmp("fwd_id_rs", fwd_id_rs, fsel(id_rs));
      cmp("fwd_id_rt", fwd_id_rt, fsel(id_rt));
    end
    cmp("fwd_ex_rs", fwd_ex_rs, fsel(m_rs[0]));
    cmp("fwd_ex_rt", fwd_ex_rt, fsel(m_rt[0]));
    cmp("fwd_mem_rt", fwd_mem_rt, live(2) && m_wa[2] == m_rt[1]);
    cmp("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic drv(int rs, int rt, int wa, bit rw, bit rs0, bit rs1,
                     bit rt0, bit rt1, bit rt2, int tn, bit h);
    id_rs = 5'(rs); id_rt = 5'(rt); id_wa = 5'(wa); id_regwrite = rw;
    id_tuse_rs0 = rs0; id_tuse_rs1 = rs1; id_tuse_rt0 = rt0;
    id_tuse_rt1 = rt1; id_tuse_rt2 = rt2; id_tnew = 2'(tn); hold = h;
  endtask

  // Instruction shorthands (ID view).
  task automatic i_nop(bit h = 0);          drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, h); endtask
  task automatic i_lw(int d, int b);        drv(b, d, d, 1, 0, 1, 0, 0, 0, 2, 0); endtask
  task automatic i_add(int d, int s, int t, bit h = 0);
                                            drv(s, t, d, 1, 0, 1, 0, 1, 0, 1, h); endtask
  task automatic i_beq(int s, int t);       drv(s, t, 0, 0, 1, 0, 1, 0, 0, 0, 0); endtask
  task automatic i_sw(int t, int b);        drv(b, t, 0, 0, 0, 1, 0, 0, 1, 0, 0); endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    i_nop();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    i_nop();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    half();
    cmp("reset_stall", stall, 0);
    cmp("reset_cnt", stall_cnt, 0);
    adv();

    // Randomized traffic on a small register set to force frequent matches
    for (int c = 0; c < 3000; c++) begin
      drv($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 2), ($urandom_range(0, 99) < 15));
      half();
      adv();
    end

    // T1: lw $1 ; add $2,$1,$3
    do_reset();
    i_lw(1, 2);       half(); adv();
    i_add(2, 1, 3);   half(); cmp("t1_stall", stall, 1); cmp("t1_bubble", ex_bubble, 1); adv();
    i_add(2, 1, 3);   half(); cmp("t1_release", stall, 0); adv();
    i_nop();          half(); cmp("t1_fwd_ex_rs", fwd_ex_rs, 2); cmp("t1_cnt", stall_cnt, 1); adv();

    // T2: add $1 ; beq $1,$4
    do_reset();
    i_add(1, 5, 6);   half(); adv();
    i_beq(1, 4);      half(); cmp("t2_stall", stall, 1); adv();
    i_beq(1, 4);      half(); cmp("t2_release", stall, 0); cmp("t2_fwd_id_rs", fwd_id_rs, 1); adv();

    // T3: lw $1 ; beq $1,$0
    do_reset();
    i_lw(1, 2);       half(); adv();
    i_beq(1, 0);      half(); cmp("t3_stall_a", stall, 1); adv();
    i_beq(1, 0);      half(); cmp("t3_stall_b", stall, 1); adv();
    i_beq(1, 0);      half(); cmp("t3_release", stall, 0); cmp("t3_fwd_id_rs", fwd_id_rs, 2);
                      cmp("t3_cnt", stall_cnt, 2); adv();

    // T4: lw $0 ; add $2,$0,$0
    do_reset();
    i_lw(0, 2);       half(); adv();
    i_add(2, 0, 0);   half(); cmp("t4_stall", stall, 0); cmp("t4_fwd_id_rs", fwd_id_rs, 0);
                      cmp("t4_fwd_id_rt", fwd_id_rt, 0); adv();
    i_nop();          half(); cmp("t4_fwd_ex_rs", fwd_ex_rs, 0); cmp("t4_fwd_ex_rt", fwd_ex_rt, 0); adv();
    i_nop();          half(); cmp("t4_fwd_mem_rt", fwd_mem_rt, 0); adv();

    // T5: lw $1 ; sw $1,0($2)
    do_reset();
    i_lw(1, 3);       half(); adv();
    i_sw(1, 2);       half(); cmp("t5_stall", stall, 0); adv();
    i_nop();          half(); adv();
    i_nop();          half(); cmp("t5_fwd_mem_rt", fwd_mem_rt, 1); adv();

    // T6: held stall, then reset mid-stall
    do_reset();
    i_lw(1, 2);       half(); adv();
    for (int h = 0; h < 3; h++) begin
      i_add(2, 1, 3, 1'b1); half();
      cmp("t6_hold_stall", stall, 1); cmp("t6_hold_bubble", ex_bubble, 0); adv();
    end
    i_add(2, 1, 3);   half(); cmp("t6_bubble", ex_bubble, 1); adv();
    i_add(2, 1, 3);   half(); cmp("t6_release", stall, 0); cmp("t6_cnt", stall_cnt, 1); adv();
    i_lw(1, 2);       half(); adv();
    i_add(2, 1, 3);   half(); cmp("t6_pre_rst_stall", stall, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("t6_rst_stall", stall, 0);
    cmp("t6_rst_bubble", ex_bubble, 0);
    cmp("t6_rst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_nop();          half(); adv();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
